// File: rtl/baud_ctrl_if.sv
// -----------------------------------------------------------------------------
// baud_ctrl_if
// Bundles the host configuration port, the TX/RX engine request/grant pairs
// and the baud generator control lines of the shared baud controller.
//
//   cfg_wr_i    host -> ctrl  one-cycle divisor write strobe
//   cfg_div_i   host -> ctrl  divisor value sampled with cfg_wr_i
//   cfg_busy_o  ctrl -> host  reconfiguration pending or in progress
//   cfg_ack_o   ctrl -> host  one-cycle pulse, new divisor active
//   cfg_err_o   ctrl -> host  one-cycle pulse, write rejected while busy
//   tx_req_i    TX -> ctrl    TX engine needs baud ticks (level)
//   rx_req_i    RX -> ctrl    RX engine needs baud ticks (level)
//   tx_gnt_o    ctrl -> TX    TX may use baud/acq ticks
//   rx_gnt_o    ctrl -> RX    RX may use baud/acq ticks
//   baud_tick_i gen -> ctrl   baud pulse, one clk wide
//   gen_hold_o  ctrl -> gen   1 holds the generator counters cleared
//   divisor_o   ctrl -> gen   divisor driven to the generator
//
// master: the side driving requests/config (host, engines, generator tick).
// slave : the baud controller itself.
// -----------------------------------------------------------------------------
interface baud_ctrl_if;
    logic        cfg_wr_i;
    logic [15:0] cfg_div_i;
    logic        cfg_busy_o;
    logic        cfg_ack_o;
    logic        cfg_err_o;
    logic        tx_req_i;
    logic        rx_req_i;
    logic        tx_gnt_o;
    logic        rx_gnt_o;
    logic        baud_tick_i;
    logic        gen_hold_o;
    logic [15:0] divisor_o;

    modport master (
        output cfg_wr_i, cfg_div_i, tx_req_i, rx_req_i, baud_tick_i,
        input  cfg_busy_o, cfg_ack_o, cfg_err_o, tx_gnt_o, rx_gnt_o,
               gen_hold_o, divisor_o
    );

    modport slave (
        input  cfg_wr_i, cfg_div_i, tx_req_i, rx_req_i, baud_tick_i,
        output cfg_busy_o, cfg_ack_o, cfg_err_o, tx_gnt_o, rx_gnt_o,
               gen_hold_o, divisor_o
    );
endinterface

// File: rtl/baud_ctrl.sv
// -----------------------------------------------------------------------------
// baud_ctrl
// Controller for the shared baud generator. Powers the generator up when TX
// or RX asks for ticks, grants service on a baud boundary, and sequences
// divisor changes so the divisor is only swapped while no frame is in flight
// and the generator is held cleared.
//
// Parameters
//   SETTLE     cycles the generator is held cleared after a divisor change
//              (legal 2..255)
//   DIV_RESET  divisor driven after reset
//
// Ports
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   baud_ctrl_if.slave (config port, engine req/gnt, generator control)
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module baud_ctrl #(
    parameter int unsigned SETTLE    = 4,
    parameter logic [15:0] DIV_RESET = 16'd26
) (
    input  logic        clk,
    input  logic        rst,
    baud_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_WARM  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    // HOLD counts down to zero inclusive, so loading SETTLE-1 gives SETTLE cycles.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 32'd1);

    state_t      r_state;
    logic        r_gen_hold;
    logic        r_tx_gnt;
    logic        r_rx_gnt;
    logic        r_busy;
    logic        r_ack;
    logic        r_err;
    logic [15:0] r_div;
    logic [15:0] r_pend;
    logic [7:0]  r_cnt;

    logic        w_accept;
    logic        w_cfg_want;
    logic [15:0] w_pend_next;
    logic        w_any_req;
    logic        w_any_gnt;

    // A write is taken only when idle; the FSM must react to it in the same
    // cycle (OFF -> HOLD in one edge), so it sees the accepted value directly
    // rather than waiting for the pending register.
    assign w_accept    = bus.cfg_wr_i & ~r_busy;
    assign w_cfg_want  = r_busy | w_accept;
    assign w_pend_next = w_accept ? bus.cfg_div_i : r_pend;
    assign w_any_req   = bus.tx_req_i | bus.rx_req_i;
    assign w_any_gnt   = r_tx_gnt | r_rx_gnt;

    // Config capture, power/grant state machine and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_OFF;
            r_gen_hold <= 1'b1;
            r_tx_gnt   <= 1'b0;
            r_rx_gnt   <= 1'b0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_div      <= DIV_RESET;
            r_pend     <= 16'd0;
            r_cnt      <= 8'd0;
        end else begin
            r_ack <= 1'b0;
            r_err <= bus.cfg_wr_i & r_busy;

            if (w_accept) begin
                r_pend <= bus.cfg_div_i;
                r_busy <= 1'b1;
            end

            case (r_state)
                S_OFF: begin
                    if (w_cfg_want) begin
                        r_state    <= S_HOLD;
                        r_gen_hold <= 1'b1;
                        r_div      <= w_pend_next;
                        r_cnt      <= SETTLE_LOAD;
                    end else if (w_any_req) begin
                        r_state    <= S_WARM;
                        r_gen_hold <= 1'b0;
                    end
                end

                S_WARM: begin
                    if (w_cfg_want) begin
                        r_state    <= S_HOLD;
                        r_gen_hold <= 1'b1;
                        r_div      <= w_pend_next;
                        r_cnt      <= SETTLE_LOAD;
                    end else if (!w_any_req) begin
                        r_state    <= S_OFF;
                        r_gen_hold <= 1'b1;
                    end else if (bus.baud_tick_i) begin
                        r_state  <= S_RUN;
                        r_tx_gnt <= bus.tx_req_i;
                        r_rx_gnt <= bus.rx_req_i;
                    end
                end

                S_RUN: begin
                    // New grants land only on a baud boundary and never once a
                    // reconfiguration is waiting; drops follow req immediately.
                    if (!bus.tx_req_i) begin
                        r_tx_gnt <= 1'b0;
                    end else if (bus.baud_tick_i && !w_cfg_want) begin
                        r_tx_gnt <= 1'b1;
                    end
                    if (!bus.rx_req_i) begin
                        r_rx_gnt <= 1'b0;
                    end else if (bus.baud_tick_i && !w_cfg_want) begin
                        r_rx_gnt <= 1'b1;
                    end

                    if (w_cfg_want) begin
                        r_state <= S_DRAIN;
                    end else if (!w_any_req && !w_any_gnt) begin
                        r_state    <= S_OFF;
                        r_gen_hold <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (!bus.tx_req_i) begin
                        r_tx_gnt <= 1'b0;
                    end
                    if (!bus.rx_req_i) begin
                        r_rx_gnt <= 1'b0;
                    end
                    // Ungranted requesters are simply held off; only live
                    // frames keep the divisor from changing.
                    if (!w_any_gnt) begin
                        r_state    <= S_HOLD;
                        r_gen_hold <= 1'b1;
                        r_div      <= w_pend_next;
                        r_cnt      <= SETTLE_LOAD;
                    end
                end

                S_HOLD: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_OFF;
                        r_busy  <= 1'b0;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                default: begin
                    r_state    <= S_OFF;
                    r_gen_hold <= 1'b1;
                    r_tx_gnt   <= 1'b0;
                    r_rx_gnt   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gen_hold_o = r_gen_hold;
    assign bus.tx_gnt_o   = r_tx_gnt;
    assign bus.rx_gnt_o   = r_rx_gnt;
    assign bus.cfg_busy_o = r_busy;
    assign bus.cfg_ack_o  = r_ack;
    assign bus.cfg_err_o  = r_err;
    assign bus.divisor_o  = r_div;

endmodule
